// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - 8N1 UART receiver: 16x oversampling, majority vote, FWFT receive FIFO.
// Optional parity state and parity_err_o enabled by defining UART_RX_PARITY_EN.
module uart_rx_deser #(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DIV_WIDTH-1:0]            cfg_div_i,
`ifdef UART_RX_PARITY_EN
  input  logic                            cfg_parity_odd_i,
  output logic                            parity_err_o,
`endif
  input  logic                            rx_i,
  output logic [7:0]                      rx_data_o,
  output logic                            rx_valid_o,
  input  logic                            rx_ready_i,
  output logic                            frame_err_o,
  output logic                            overrun_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t state_q, state_d;

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [3:0]           samp_q;
  logic [2:0]           bit_q;
  logic [7:0]           shreg_q;
  logic                 v7_q, v8_q;
  logic                 frame_err_q, overrun_q;

  logic tick, maj, at9, at15, fall_edge;
  logic start_frame, shift_en, bit_done, stop_dec, push_req, ferr_req;

  // >= rather than == so a divisor lowered mid-frame still produces ticks.
  assign tick      = (cnt_q >= cfg_div_i);
  assign at9       = tick && (samp_q == 4'd9);
  assign at15      = tick && (samp_q == 4'd15);
  assign maj       = (v7_q & v8_q) | (v7_q & rx_s_q) | (v8_q & rx_s_q);
  assign fall_edge = rx_prev_q && !rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (fall_edge) state_d = S_START;
      S_START: begin
        if (at9 && maj) state_d = S_IDLE;
        else if (at15)  state_d = S_DATA;
      end
`ifdef UART_RX_PARITY_EN
      S_DATA:      if (at15 && bit_q == 3'd7) state_d = S_PARITY;
      S_PARITY:    if (at15) state_d = S_STOP;
`else
      S_DATA:      if (at15 && bit_q == 3'd7) state_d = S_STOP;
`endif
      S_STOP:      if (at9) state_d = maj ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_s_q) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_frame = (state_q == S_IDLE) && fall_edge;
    shift_en    = (state_q == S_DATA) && at9;
    bit_done    = (state_q == S_DATA) && at15;
    stop_dec    = (state_q == S_STOP) && at9;
    push_req    = stop_dec && maj;
    ferr_req    = stop_dec && !maj;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      samp_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      v7_q      <= 1'b0;
      v8_q      <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      if (start_frame) begin
        cnt_q  <= '0;
        samp_q <= '0;
        bit_q  <= '0;
      end else begin
        cnt_q <= tick ? '0 : cnt_q + 1'b1;
        if (tick)     samp_q <= samp_q + 4'd1;
        if (bit_done) bit_q  <= bit_q + 3'd1;
      end
      if (tick && samp_q == 4'd7) v7_q <= rx_s_q;
      if (tick && samp_q == 4'd8) v8_q <= rx_s_q;
      if (shift_en) shreg_q <= {maj, shreg_q[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, parity_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      if (state_q == S_PARITY && at9) par_q <= maj;
      parity_err_q <= stop_dec && ((^shreg_q ^ par_q) != cfg_parity_odd_i);
    end
  end
  assign parity_err_o = parity_err_q;
`endif

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             pop, full, wr_en;

  assign pop   = (level_q != '0) && rx_ready_i;
  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= shreg_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      frame_err_q <= ferr_req;
      overrun_q   <= push_req && full && !pop;
    end
  end

  assign rx_valid_o   = (level_q != '0);
  assign rx_data_o    = rx_valid_o ? mem[rd_ptr_q] : 8'h00;
  assign fifo_level_o = level_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb/tb_uart_rx_deser.sv - scoreboard bench for uart_rx_deser (honours UART_RX_PARITY_EN).
module tb_uart_rx_deser;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_div_i = 16'd1;
  logic        rx_i = 1'b1;
  logic        rx_ready_i = 1'b0;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o, frame_err_o, overrun_o;
  logic [3:0]  fifo_level_o;
`ifdef UART_RX_PARITY_EN
  logic        cfg_parity_odd_i = 1'b0;
  logic        parity_err_o;
  bit          bad_parity = 1'b0;
`endif

  uart_rx_deser #(.DIV_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_div_i(cfg_div_i),
`ifdef UART_RX_PARITY_EN
    .cfg_parity_odd_i(cfg_parity_odd_i), .parity_err_o(parity_err_o),
`endif
    .rx_i(rx_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o), .fifo_level_o(fifo_level_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int t0 = 0, rise_cyc = 0, lat = 311;
  int exp_ferr = 0, obs_ferr = 0, exp_ovr = 0, obs_ovr = 0, exp_perr = 0, obs_perr = 0;
  logic [7:0] exp_q [$];
  bit   rand_ready = 1'b0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT pop is checked against the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid_o && rx_ready_i) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%0h expected no data (cycle %0d)", rx_data_o, cyc);
        end else begin
          chk("pop_data", {24'd0, rx_data_o}, {24'd0, exp_q.pop_front()});
        end
      end
      if (frame_err_o) obs_ferr++;
      if (overrun_o)   obs_ovr++;
`ifdef UART_RX_PARITY_EN
      if (parity_err_o) obs_perr++;
`endif
      if (frame_err_o || overrun_o) chk("err_exclusive", {31'd0, frame_err_o & overrun_o}, 32'd0);
      if (rx_valid_o && !prev_valid) rise_cyc = cyc;
    end
    prev_valid = rx_valid_o;
  end

  always @(posedge clk) begin
    #2;
    if (rand_ready) rx_ready_i = 1'($urandom_range(0, 1));
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bit_clks();
    return 16 * (int'(cfg_div_i) + 1);
  endfunction

  // Reference model: a good frame lands in the FIFO unless it already holds DEPTH
  // unread bytes (force_acc covers a pop scheduled in the push cycle).
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit force_acc);
    int bc;
    bc = bit_clks();
    if (!stop_ok) exp_ferr++;
    else if (exp_q.size() < DEPTH || force_acc) exp_q.push_back(b);
    else exp_ovr++;
`ifdef UART_RX_PARITY_EN
    if (bad_parity) exp_perr++;
`endif
    t0 = cyc;
    rx_i = 1'b0;
    wait_clk(bc);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_clk(bc);
    end
`ifdef UART_RX_PARITY_EN
    rx_i = (^b) ^ cfg_parity_odd_i ^ bad_parity;
    wait_clk(bc);
`endif
    rx_i = stop_ok;
    wait_clk(bc);
    rx_i = 1'b1;
  endtask

  task automatic drain(input string name);
    rx_ready_i = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_clk(1);
    wait_clk(2);
    rx_ready_i = 1'b0;
    chk({name, "_sb_empty"}, exp_q.size(), 32'd0);
    chk({name, "_level0"}, {28'd0, fifo_level_o}, 32'd0);
  endtask

  initial begin
    wait_clk(4);
    chk("rst_valid", {31'd0, rx_valid_o}, 32'd0);
    chk("rst_data", {24'd0, rx_data_o}, 32'd0);
    chk("rst_level", {28'd0, fifo_level_o}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err_o}, 32'd0);
    chk("rst_ovr", {31'd0, overrun_o}, 32'd0);
    rst = 1'b0;
    wait_clk(5);

    // Single byte, latency of valid after the stop-bit centre.
    send_byte(8'hA5, 1'b1, 1'b0);
    wait_clk(8);
    chk("lat_window", {31'd0, (rise_cyc - t0 >= 306) && (rise_cyc - t0 <= 314)}, 32'd1);
    lat = rise_cyc - t0;
    chk("a5_level", {28'd0, fifo_level_o}, 32'd1);
    chk("a5_head", {24'd0, rx_data_o}, 32'hA5);
    rx_ready_i = 1'b1;
    wait_clk(1);
    rx_ready_i = 1'b0;
    wait_clk(2);
    chk("a5_pop_level", {28'd0, fifo_level_o}, 32'd0);

    // 3-clk glitch is rejected silently.
    rx_i = 1'b0;
    wait_clk(3);
    rx_i = 1'b1;
    wait_clk(100);
    chk("glitch_level", {28'd0, fifo_level_o}, 32'd0);
    chk("glitch_ferr", obs_ferr, 32'd0);

    // Bad stop then 100-bit break: one frame error, then recovery.
    rx_ready_i = 1'b1;
    send_byte(8'h3C, 1'b0, 1'b0);
    rx_i = 1'b0;
    wait_clk(100 * bit_clks());
    rx_i = 1'b1;
    wait_clk(64);
    chk("break_ferr_once", obs_ferr, 32'd1);
    chk("break_level", {28'd0, fifo_level_o}, 32'd0);
    send_byte(8'h55, 1'b1, 1'b0);
    wait_clk(64);
    drain("break");

    // Nine bytes with consumer stalled: ninth overruns.
    rx_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send_byte(8'(i), 1'b1, 1'b0);
      wait_clk(32);
    end
    wait_clk(32);
    chk("ovr_level_full", {28'd0, fifo_level_o}, 32'd8);
    chk("ovr_count", obs_ovr, 32'd1);
    drain("ovr");

    // Full FIFO with a pop in the push cycle: no overrun, new byte stored.
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h10 + 8'(i), 1'b1, 1'b0);
      wait_clk(32);
    end
    chk("pp_full", {28'd0, fifo_level_o}, 32'd8);
    fork
      send_byte(8'h18, 1'b1, 1'b1);
      begin
        wait_clk(lat - 1);
        rx_ready_i = 1'b1;
        wait_clk(1);
        rx_ready_i = 1'b0;
      end
    join
    wait_clk(32);
    chk("pp_level", {28'd0, fifo_level_o}, 32'd8);
    chk("pp_no_ovr", obs_ovr, 32'd1);
    drain("pp");

    // Reset in the middle of 0xFF, then 0x81.
    rx_i = 1'b0;
    wait_clk(bit_clks());
    rx_i = 1'b1;
    wait_clk(3 * bit_clks());
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(bit_clks());
`ifdef UART_RX_PARITY_EN
    cfg_parity_odd_i = 1'b1;
    bad_parity = 1'b1;
`endif
    rx_ready_i = 1'b1;
    send_byte(8'h81, 1'b1, 1'b0);
    wait_clk(64);
`ifdef UART_RX_PARITY_EN
    bad_parity = 1'b0;
    chk("parity_err_once", obs_perr, 32'd1);
`endif
    drain("rst81");

    // Random bytes, divisors, stop errors and consumer backpressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cfg_div_i = 16'($urandom_range(1, 3));
`ifdef UART_RX_PARITY_EN
      cfg_parity_odd_i = 1'($urandom_range(0, 1));
      bad_parity = ($urandom_range(0, 4) == 0);
`endif
      send_byte(8'($urandom), ($urandom_range(0, 5) != 0), 1'b0);
      wait_clk(2 * bit_clks() + int'($urandom_range(0, 40)));
    end
    rand_ready = 1'b0;
    wait_clk(1);
    drain("rand");
    chk("ferr_total", obs_ferr, exp_ferr);
    chk("ovr_total", obs_ovr, exp_ovr);
`ifdef UART_RX_PARITY_EN
    chk("perr_total", obs_perr, exp_perr);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
